// File: rtl/as6s_vp_buffer_fifo_stream_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | as6s_vp_buffer_fifo_stream_adapter: credit-limited FIFO read port to valid/ready     |
// | stream through a small circular skid buffer.                  Revision 1.0           |
// +--------------------------------------------------------------------------------------+
module as6s_vp_buffer_fifo_stream_adapter #(
   parameter int DATA_WIDTH     = 128,
   parameter int RAM_PIPE_STAGE = 2,
   parameter int SKID_DEPTH     = RAM_PIPE_STAGE + 2,
   parameter int CNT_W          = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_trans_clr,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_data_val,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_W-1:0]      skid_level,
   output logic [CNT_W-1:0]      inflight,
   output logic                  ovf_err,
   output logic                  unexp_val_err
);

   localparam int               PTR_W     = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(SKID_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(SKID_DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SKID_DEPTH - 1);

   logic [DATA_WIDTH-1:0] entry [SKID_DEPTH];
   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic [CNT_W:0]        credit;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  store;
   logic                  drop;
   logic                  unexp;
   logic                  infl_dec;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Every outstanding read already owns a skid slot, so returning data never overflows.
   assign credit     = DEPTH_EXT - {1'b0, skid_level} - {1'b0, inflight};
   assign fifo_rd_en = !rst && !fifo_empty && (credit != '0) && !data_trans_clr;

   assign push     = fifo_rd_data_val && !data_trans_clr;
   assign pop      = m_valid && m_ready;
   assign full     = (skid_level == DEPTH_LVL);
   assign store    = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign unexp    = push && (inflight == '0);
   assign infl_dec = push && (inflight != '0);

   assign m_valid = (skid_level != '0);
   assign m_data  = entry[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_level    <= '0;
         inflight      <= '0;
         wptr          <= '0;
         rptr          <= '0;
         ovf_err       <= 1'b0;
         unexp_val_err <= 1'b0;
      end else if (data_trans_clr) begin
         skid_level    <= '0;
         inflight      <= '0;
         wptr          <= '0;
         rptr          <= '0;
         ovf_err       <= 1'b0;
         unexp_val_err <= 1'b0;
      end else begin
         if (store) wptr <= ptr_inc(wptr);
         if (pop)   rptr <= ptr_inc(rptr);
         case ({store, pop})
            2'b10:   skid_level <= skid_level + 1'b1;
            2'b01:   skid_level <= skid_level - 1'b1;
            default: skid_level <= skid_level;
         endcase
         case ({fifo_rd_en, infl_dec})
            2'b10:   inflight <= inflight + 1'b1;
            2'b01:   inflight <= inflight - 1'b1;
            default: inflight <= inflight;
         endcase
         ovf_err       <= drop;
         unexp_val_err <= unexp;
      end
   end

   // Storage is deliberately left out of reset; it is only observed while m_valid is high.
   always_ff @(posedge clk) begin
      if (store) entry[wptr] <= fifo_rd_data;
   end

endmodule
`default_nettype wire

// File: tb/tb_as6s_vp_buffer_fifo_stream_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | tb_as6s_vp_buffer_fifo_stream_adapter: randomized scoreboard bench with a FIFO model. |
// | Revision 1.0                                                                          |
// +--------------------------------------------------------------------------------------+
module tb_as6s_vp_buffer_fifo_stream_adapter;

   localparam int DW    = 128;
   localparam int RPS   = 2;
   localparam int DEPTH = RPS + 2;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          data_trans_clr = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          fifo_rd_data_val = 1'b0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [CW-1:0] skid_level;
   logic [CW-1:0] inflight;
   logic          ovf_err;
   logic          unexp_val_err;

   as6s_vp_buffer_fifo_stream_adapter #(
      .DATA_WIDTH(DW), .RAM_PIPE_STAGE(RPS), .SKID_DEPTH(DEPTH), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .data_trans_clr(data_trans_clr), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .fifo_rd_data_val(fifo_rd_data_val), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .skid_level(skid_level), .inflight(inflight), .ovf_err(ovf_err),
      .unexp_val_err(unexp_val_err)
   );

   always #5 clk = ~clk;

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] fifo_q [$];
   logic [DW-1:0] exp_q [$];
   bit            vpipe [RPS];
   logic [DW-1:0] dpipe [RPS];
   int            mlevel, minfl;
   bit            e_ovf, e_unexp;
   int            ready_pct = 100;
   bit            rst_req = 1'b1, rst_prev = 1'b0, clr_req = 1'b0, force_req = 1'b0;
   logic [DW-1:0] force_data = '0;
   bit            hold_pending = 1'b0;
   logic [DW-1:0] hold_data = '0;

   function automatic void chk(input string name, input logic [DW-1:0] act,
                               input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic void reset_model();
      mlevel  = 0;
      minfl   = 0;
      e_ovf   = 1'b0;
      e_unexp = 1'b0;
      exp_q.delete();
      fifo_q.delete();
      for (int i = 0; i < RPS; i++) vpipe[i] = 1'b0;
   endfunction

   // Monitor: pops the scoreboard on every accepted word and checks stall stability.
   always @(negedge clk) begin
      if (!rst && hold_pending) begin
         chk("hold_valid", DW'(m_valid), DW'(1));
         chk("hold_data", m_data, hold_data);
      end
      hold_pending = 1'b0;
      if (!rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) chk("extra_word", m_data, 'x);
         else chk("m_data", m_data, exp_q.pop_front());
      end
      if (!rst && m_valid && !m_ready && !data_trans_clr) begin
         hold_pending = 1'b1;
         hold_data    = m_data;
      end
   end

   task automatic cycle();
      bit rd, v, pop_m, full, acc, exp_rd;
      logic [DW-1:0] w;
      @(posedge clk);
      #1;
      rst = rst_req;
      if (rst) reset_model();
      data_trans_clr   = clr_req;
      m_ready          = ($urandom_range(0, 99) < ready_pct);
      fifo_empty       = (fifo_q.size() == 0);
      fifo_rd_data_val = vpipe[RPS-1] | force_req;
      fifo_rd_data     = force_req ? force_data : dpipe[RPS-1];
      if (rst && !rst_prev) begin
         #1;
         chk("rst_m_valid", DW'(m_valid), '0);
         chk("rst_rd_en", DW'(fifo_rd_en), '0);
      end
      rst_prev = rst;
      @(negedge clk);
      exp_rd = !rst && !fifo_empty && (DEPTH - mlevel - minfl != 0) && !data_trans_clr;
      chk("fifo_rd_en", DW'(fifo_rd_en), DW'(exp_rd));
      chk("m_valid", DW'(m_valid), DW'(mlevel != 0));
      chk("skid_level", DW'(skid_level), DW'(mlevel));
      chk("inflight", DW'(inflight), DW'(minfl));
      chk("ovf_err", DW'(ovf_err), DW'(e_ovf));
      chk("unexp_val_err", DW'(unexp_val_err), DW'(e_unexp));
      #1;
      rd    = fifo_rd_en;
      v     = fifo_rd_data_val;
      pop_m = (mlevel != 0) && m_ready;
      if (rst) begin
         reset_model();
      end else if (data_trans_clr) begin
         reset_model();
      end else begin
         full    = (mlevel == DEPTH);
         e_unexp = v && (minfl == 0);
         e_ovf   = v && full && !pop_m;
         acc     = v && !(full && !pop_m);
         if (force_req && acc) exp_q.push_back(force_data);
         minfl  = minfl + int'(rd) - ((v && minfl > 0) ? 1 : 0);
         mlevel = mlevel + int'(acc) - int'(pop_m);
         for (int i = RPS - 1; i > 0; i--) begin
            vpipe[i] = vpipe[i-1];
            dpipe[i] = dpipe[i-1];
         end
         vpipe[0] = rd;
         if (rd) begin
            w = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
            dpipe[0] = w;
            exp_q.push_back(w);
         end
      end
      clr_req   = 1'b0;
      force_req = 1'b0;
   endtask

   task automatic random_run(input int ncyc, input int pct);
      ready_pct = pct;
      for (int i = 0; i < ncyc; i++) begin
         if (fifo_q.size() < 3 && $urandom_range(0, 3) != 0) fifo_q.push_back(rnd_word());
         cycle();
      end
   endtask

   task automatic drain(input int bound);
      int n = 0;
      ready_pct = 100;
      while ((fifo_q.size() != 0 || mlevel != 0 || minfl != 0) && n < bound) begin
         cycle();
         n++;
      end
      chk("drain_done", DW'(n < bound), DW'(1));
   endtask

   initial begin
      int first_v, rd_cnt, n;
      rst_req = 1'b1;
      repeat (3) cycle();
      rst_req = 1'b0;

      // 16 preloaded words at full rate
      for (int i = 0; i < 16; i++) fifo_q.push_back(rnd_word());
      ready_pct = 100;
      first_v = -1;
      rd_cnt = 0;
      for (int k = 0; k < 25; k++) begin
         cycle();
         if (k < 16 && fifo_rd_en) rd_cnt++;
         if (m_valid && first_v < 0) first_v = k;
      end
      chk("p1_rd_burst", DW'(rd_cnt), DW'(16));
      chk("p1_first_valid", DW'(first_v), DW'(RPS + 1));

      // backpressure: credit caps reads at the skid depth
      for (int i = 0; i < 8; i++) fifo_q.push_back(rnd_word());
      ready_pct = 0;
      repeat (20) cycle();
      chk("p2_level", DW'(skid_level), DW'(DEPTH));
      chk("p2_inflight", DW'(inflight), '0);
      drain(40);

      random_run(60, 50);
      random_run(160, $urandom_range(20, 90));
      drain(60);

      // clear with reads outstanding and words buffered
      for (int i = 0; i < 6; i++) fifo_q.push_back(rnd_word());
      ready_pct = 0;
      n = 0;
      while (!(mlevel >= 2 && minfl >= 1) && n < 20) begin
         cycle();
         n++;
      end
      chk("clr_setup", DW'(n < 20), DW'(1));
      clr_req = 1'b1;
      cycle();
      cycle();
      chk("clr_level", DW'(skid_level), '0);
      chk("clr_inflight", DW'(inflight), '0);
      chk("clr_m_valid", DW'(m_valid), '0);
      for (int i = 0; i < 4; i++) fifo_q.push_back(rnd_word());
      drain(30);

      // forced returns: unexpected val, then overflow at full
      ready_pct = 0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         force_data = rnd_word();
         force_req  = 1'b1;
         cycle();
      end
      repeat (2) cycle();
      chk("force_level", DW'(skid_level), DW'(DEPTH));
      drain(20);

      // asynchronous reset in the middle of traffic
      random_run(30, 70);
      rst_req = 1'b1;
      cycle();
      rst_req = 1'b0;
      random_run(60, 60);
      drain(60);
      repeat (3) cycle();
      chk("scoreboard_empty", DW'(exp_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
